fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_write_arbiter.sv | 98 +++++++++
 tb/tb_fifo_write_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter for the async FIFO write port
module fifo_write_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_write_en,
    output logic [WIDTH-1:0]             fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         burst_done
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [CNTW-1:0] beat_cnt;

    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  cand;
    logic            found;
    logic            xfer;
    logic            last_beat;
    logic [IDW-1:0]  next_ptr;

    // First valid requester at or after rr_ptr, with explicit modulo for non-power-of-2 counts
    always_comb begin
        pick  = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign busy          = (state == BURST);
    assign xfer          = busy & req_valid[grant_id] & ~fifo_full;
    assign fifo_write_en = xfer;
    assign fifo_data_in  = req_data[grant_id*WIDTH +: WIDTH];
    assign last_beat     = req_last[grant_id] | (beat_cnt == CNTW'(MAX_BURST - 1));
    assign next_ptr      = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            beat_cnt   <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // Stalls (owner bubble or full FIFO) simply hold every register
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            rr_ptr     <= next_ptr;
                            state      <= IDLE;
                            burst_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - randomized and directed check of fifo_write_arbiter against a queue-level model
module tb_fifo_write_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_write_en;
    logic [W-1:0]   fifo_data_in;
    logic [1:0]     grant_id;
    logic           busy;
    logic           burst_done;

    fifo_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
        .grant_id(grant_id), .busy(busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: owner (-1 when idle), beats moved in this burst, next search start, last owner
    int seq [N];
    int m_owner, m_beats, m_ptr, m_gid;
    bit m_done;

    int n_wr, n_done, s_gid;
    int glog[$];
    bit prev_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_ptr = 0; m_gid = 0; m_done = 0;
        prev_busy = 0;
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance the model after the edge
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        logic         e_busy, e_wr;
        logic [N-1:0] e_ready;
        logic [W-1:0] e_data;
        req_valid = v; req_last = l; fifo_full = f;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = {8'(i), 24'(seq[i])};
        e_busy  = (m_owner >= 0);
        e_wr    = 1'b0;
        e_ready = '0;
        if (e_busy) e_wr = v[m_owner] & ~f;
        if (e_wr) e_ready[m_owner] = 1'b1;
        e_data = {8'(m_gid), 24'(seq[m_gid])};
        @(negedge clk);
        check("busy", 64'(busy), 64'(e_busy));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        check("write_en", 64'(fifo_write_en), 64'(e_wr));
        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("data_in", 64'(fifo_data_in), 64'(e_data));
        check("burst_done", 64'(burst_done), 64'(m_done));
        s_gid = int'(grant_id);
        if (busy && !prev_busy) glog.push_back(int'(grant_id));
        prev_busy = busy;
        if (fifo_write_en) n_wr++;
        if (burst_done) n_done++;
        @(posedge clk);
        #1;
        m_done = 0;
        if (m_owner < 0) begin
            for (int d = 0; d < N; d++) begin
                if (m_owner < 0 && v[(m_ptr + d) % N]) begin
                    m_owner = (m_ptr + d) % N;
                    m_gid   = m_owner;
                    m_beats = 0;
                end
            end
        end else if (e_wr) begin
            seq[m_owner]++;
            m_beats++;
            if (l[m_owner] || m_beats == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_done  = 1;
            end
        end
    endtask

    task automatic do_reset();
        logic [W-1:0] d0;
        req_valid = N'($urandom);
        req_last  = N'($urandom);
        fifo_full = 1'($urandom);
        for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
        d0 = req_data[W-1:0];
        rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_write_en", 64'(fifo_write_en), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_burst_done", 64'(burst_done), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_data_in", 64'(fifo_data_in), 64'(d0));
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && m_owner >= 0; k++) step('1, '1, 1'b0);
        step('0, '0, 1'b0);
    endtask

    initial begin
        int rot_exp[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) seq[i] = 0;
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        model_reset();
        n_wr = 0; n_done = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Rotation with all requesters continuously valid
        glog.delete(); n_wr = 0; n_done = 0;
        for (int c = 0; c < 25; c++) step('1, '0, 1'b0);
        check("rot_grant_count", 64'(glog.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            check($sformatf("rot_grant%0d", k), 64'((k < glog.size()) ? glog[k] : 99), 64'(rot_exp[k]));
        check("rot_writes", 64'(n_wr), 64'd20);
        check("rot_done_pulses", 64'(n_done), 64'd4);

        // Early last from requester 2, then 0 and 3 compete
        n_wr = 0;
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        check("early_grant", 64'(s_gid), 64'd2);
        step(4'b0100, 4'b0100, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        check("early_writes", 64'(n_wr), 64'd2);
        step(4'b1001, 4'b0000, 1'b0);
        step(4'b1001, 4'b0000, 1'b0);
        check("early_next_grant", 64'(s_gid), 64'd3);
        drain();

        // FIFO full stall mid-burst
        n_wr = 0;
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 4'b0000, 1'b1);
            check("stall_grant", 64'(s_gid), 64'd1);
        end
        check("stall_writes", 64'(n_wr), 64'd1);
        for (int c = 0; c < 3; c++) step(4'b1111, 4'b0000, 1'b0);
        check("stall_burst_writes", 64'(n_wr), 64'd4);
        drain();

        // Owner bubble while others are valid
        n_wr = 0;
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(4'b1110, 4'b0000, 1'b0);
            check("bubble_grant", 64'(s_gid), 64'd0);
        end
        check("bubble_writes", 64'(n_wr), 64'd1);
        for (int c = 0; c < 3; c++) step(4'b1111, 4'b0000, 1'b0);
        check("bubble_burst_writes", 64'(n_wr), 64'd4);
        drain();

        // Reset mid-burst of requester 1
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        req_valid = 4'b0010;
        #1;
        do_reset();
        step('1, '0, 1'b0);
        step('1, '0, 1'b0);
        check("post_rst_grant", 64'(s_gid), 64'd0);
        drain();

        // Randomized traffic
        for (int c = 0; c < 3000; c++)
            step(N'($urandom), N'($urandom) & N'($urandom), ($urandom_range(0, 3) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
